// File: rtl/iru_rot_fp.sv
// iru_rot_fp -- image rotation unit.
// Takes a 20x20 8-bit window and the rotation-detection angle vector. It
// de-rotates the window by 10 deg * (lowest set bit of the angle vector)
// using nearest-neighbour sampling, writing one destination pixel per cycle.
// Pipeline: counter -> coordinate transform (registered) -> bounds check,
// source fetch and write into q.
// Latency: out_valid rises exactly 401 clock edges after the accept edge.
// That is 400 counter cycles plus one coordinate pipeline register.
module iru_rot_fp #(
  parameter int IMG_DIM    = 20,
  parameter int NUM_ANGLES = 36,
  parameter int COEF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdn_out_rdy,
  input  logic [NUM_ANGLES-1:0] angle_in,
  input  logic [4:0][79:0][7:0] d,
  input  logic                  nxt_in_rdy,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [4:0][79:0][7:0] q
);

  localparam int         PIX    = IMG_DIM * IMG_DIM;
  localparam logic [8:0] K_LAST = 9'(PIX - 1);
  localparam logic [4:0] C_LAST = 5'(IMG_DIM - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROT  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Lowest set bit of the angle vector; an all-zero vector means identity.
  function automatic logic [5:0] angle_idx(input logic [NUM_ANGLES-1:0] v);
    logic [5:0] r;
    r = 6'd0;
    for (int i = NUM_ANGLES - 1; i >= 0; i--) begin
      if (v[i]) r = 6'(i);
      else      r = r;
    end
    return r;
  endfunction

  // First-quadrant sine table: round(16384*sin(10deg*j)), j = 0..9.
  function automatic logic signed [15:0] sin_q1(input logic [3:0] j);
    logic signed [15:0] v;
    case (j)
      4'd0:    v = 16'sd0;
      4'd1:    v = 16'sd2845;
      4'd2:    v = 16'sd5604;
      4'd3:    v = 16'sd8192;
      4'd4:    v = 16'sd10531;
      4'd5:    v = 16'sd12551;
      4'd6:    v = 16'sd14189;
      4'd7:    v = 16'sd15396;
      4'd8:    v = 16'sd16135;
      4'd9:    v = 16'sd16384;
      default: v = 16'sd0;
    endcase
    return v;
  endfunction

  // Full-circle sine derived from the first quadrant by symmetry. i is in 0..44.
  function automatic logic signed [15:0] sin_lut(input logic [5:0] i);
    logic [5:0]         m;
    logic signed [15:0] v;
    if (i >= 6'd36) m = i - 6'd36;
    else            m = i;
    if (m < 6'd9)       v = sin_q1(m[3:0]);
    else if (m < 6'd18) v = sin_q1(4'(6'd18 - m));
    else if (m < 6'd27) v = -sin_q1(4'(m - 6'd18));
    else                v = -sin_q1(4'(6'd36 - m));
    return v;
  endfunction

  // Cosine is sine shifted by a quarter turn (9 steps).
  function automatic logic signed [15:0] cos_lut(input logic [5:0] i);
    return sin_lut(i + 6'd9);
  endfunction

  logic [1:0]               state_r;
  logic [8:0]               k_r;
  logic [4:0]               row_r;
  logic [4:0]               col_r;
  logic                     issuing_r;
  logic signed [COEF_W-1:0] cos_r;
  logic signed [COEF_W-1:0] sin_r;
  logic [399:0][7:0]        src_r;
  logic [399:0][7:0]        q_r;

  logic                     p1_valid_r;
  logic                     p1_last_r;
  logic [8:0]               p1_dst_r;
  logic signed [8:0]        p1_sc_r;
  logic signed [8:0]        p1_sr_r;

  logic                     accept_s;
  logic signed [23:0]       dx_s;
  logic signed [23:0]       dy_s;
  logic signed [23:0]       cos_x_s;
  logic signed [23:0]       sin_x_s;
  logic signed [23:0]       px_s;
  logic signed [23:0]       py_s;
  logic signed [8:0]        sc_s;
  logic signed [8:0]        sr_s;
  logic                     in_bounds_s;
  logic [8:0]               src_idx_s;
  logic [7:0]               pix_s;

  assign accept_s = (state_r == S_IDLE) && in_ready && rdn_out_rdy;
  assign q        = q_r;

  // Doubled centred coordinates rotated by the latched sin/cos.
  // The +20*16384 offset plus >>>15 floors to the rounded source pixel.
  always_comb begin
    dx_s    = $signed({18'd0, col_r, 1'b0}) - 24'sd19;
    dy_s    = $signed({18'd0, row_r, 1'b0}) - 24'sd19;
    cos_x_s = {{(24 - COEF_W){cos_r[COEF_W-1]}}, cos_r};
    sin_x_s = {{(24 - COEF_W){sin_r[COEF_W-1]}}, sin_r};
    px_s    = cos_x_s * dx_s - sin_x_s * dy_s + 24'sd327680;
    py_s    = sin_x_s * dx_s + cos_x_s * dy_s + 24'sd327680;
    sc_s    = 9'(px_s >>> 15);
    sr_s    = 9'(py_s >>> 15);
  end

  // Bounds check and nearest-neighbour fetch from the captured source window.
  always_comb begin
    in_bounds_s = (p1_sc_r >= 9'sd0) && (p1_sc_r <= 9'sd19) &&
                  (p1_sr_r >= 9'sd0) && (p1_sr_r <= 9'sd19);
    src_idx_s   = 9'(p1_sr_r[4:0]) * 9'd20 + 9'(p1_sc_r[4:0]);
    if (in_bounds_s) pix_s = src_r[src_idx_s];
    else             pix_s = 8'h00;
  end

  // Control FSM, pixel counter and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      k_r       <= 9'd0;
      row_r     <= 5'd0;
      col_r     <= 5'd0;
      issuing_r <= 1'b0;
      cos_r     <= '0;
      sin_r     <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            state_r   <= S_ROT;
            in_ready  <= 1'b0;
            k_r       <= 9'd0;
            row_r     <= 5'd0;
            col_r     <= 5'd0;
            issuing_r <= 1'b1;
            cos_r     <= cos_lut(angle_idx(angle_in));
            sin_r     <= sin_lut(angle_idx(angle_in));
          end else begin
            in_ready  <= 1'b1;
          end
        end
        S_ROT: begin
          if (issuing_r) begin
            if (k_r == K_LAST) begin
              issuing_r <= 1'b0;
            end else begin
              k_r <= k_r + 9'd1;
              if (col_r == C_LAST) begin
                col_r <= 5'd0;
                row_r <= row_r + 5'd1;
              end else begin
                col_r <= col_r + 5'd1;
              end
            end
          end
          if (p1_valid_r && p1_last_r) begin
            state_r   <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (nxt_in_rdy) begin
            state_r   <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          issuing_r <= 1'b0;
        end
      endcase
    end
  end

  // Coordinate pipeline register between the transform and the fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid_r <= 1'b0;
      p1_last_r  <= 1'b0;
      p1_dst_r   <= 9'd0;
      p1_sc_r    <= 9'sd0;
      p1_sr_r    <= 9'sd0;
    end else begin
      p1_valid_r <= (state_r == S_ROT) && issuing_r;
      p1_last_r  <= (k_r == K_LAST);
      p1_dst_r   <= k_r;
      p1_sc_r    <= sc_s;
      p1_sr_r    <= sr_s;
    end
  end

  // Source window capture, taken once on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_r <= '0;
    end else if (accept_s) begin
      src_r <= d;
    end
  end

  // Destination window; written only while rotating, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if ((state_r == S_ROT) && p1_valid_r) begin
      q_r[p1_dst_r] <= pix_s;
    end
  end

endmodule

// File: tb/tb_iru_rot_fp.sv
// Testbench for iru_rot_fp: a driver pushes reference frames into a
// scoreboard queue on each accept, and a monitor pops and compares them
// whenever out_valid rises.
module tb_iru_rot_fp;

  typedef logic [399:0][7:0] frame_t;

  logic                  clk         = 1'b0;
  logic                  rst_n       = 1'b0;
  logic                  rdn_out_rdy = 1'b0;
  logic                  nxt_in_rdy  = 1'b1;
  logic [35:0]           angle_in    = 36'h0;
  logic [4:0][79:0][7:0] d           = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic [4:0][79:0][7:0] q;

  frame_t exp_q[$];
  longint acc_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  iru_rot_fp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdn_out_rdy(rdn_out_rdy),
    .angle_in   (angle_in),
    .d          (d),
    .nxt_in_rdy (nxt_in_rdy),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .q          (q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: rotate with real-valued trig tables and floor arithmetic.
  function automatic frame_t model(input frame_t src, input logic [35:0] ang);
    frame_t res;
    int     idx, cs, sn, dx, dy, px, py, sc, sr;
    real    th;
    idx = 0;
    for (int i = 35; i >= 0; i--) if (ang[i]) idx = i;
    th = 3.14159265358979323846 * real'(idx * 10) / 180.0;
    cs = $rtoi($floor(16384.0 * $cos(th) + 0.5));
    sn = $rtoi($floor(16384.0 * $sin(th) + 0.5));
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 20; c++) begin
        dx = 2 * c - 19;
        dy = 2 * r - 19;
        px = cs * dx - sn * dy;
        py = sn * dx + cs * dy;
        sc = $rtoi($floor(real'(px + 20 * 16384) / 32768.0));
        sr = $rtoi($floor(real'(py + 20 * 16384) / 32768.0));
        if (sc >= 0 && sc <= 19 && sr >= 0 && sr <= 19) res[r*20+c] = src[sr*20+sc];
        else                                            res[r*20+c] = 8'h00;
      end
    end
    return res;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < 400; i++) f[i] = 8'($urandom);
    return f;
  endfunction

  // Present a window until it is accepted, then scramble the inputs.
  task automatic send(input frame_t f, input logic [35:0] ang);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready still %0b after %0d cycles, required 1", in_ready, n);
    end else begin
      d           = f;
      angle_in    = ang;
      rdn_out_rdy = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(model(f, ang));
      acc_q.push_back(cyc);
      rdn_out_rdy = 1'b0;
      d           = rand_frame();
      angle_in    = {4'($urandom), 32'($urandom)};
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL idle_timeout: in_ready %0b, required 1", in_ready);
    end
  endtask

  task automatic check_pix(input string name, input int r, input int c, input logic [7:0] expv);
    frame_t qf;
    qf = q;
    checks++;
    if (qf[r*20+c] !== expv) begin
      errors++;
      $display("FAIL %s: q(%0d,%0d) got 0x%02h, required 0x%02h", name, r, c, qf[r*20+c], expv);
    end
  endtask

  // Monitor: compare each completed frame against the scoreboard head.
  initial begin : monitor
    logic   ov_prev;
    frame_t e;
    frame_t got;
    longint a;
    int     bad;
    int     nframe;
    ov_prev = 1'b0;
    nframe  = 0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !ov_prev) begin
        got = q;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: out_valid rose with no frame pending");
        end else begin
          e   = exp_q.pop_front();
          a   = acc_q.pop_front();
          bad = -1;
          for (int i = 0; i < 400; i++) if (bad < 0 && got[i] !== e[i]) bad = i;
          checks++;
          if (bad >= 0) begin
            errors++;
            $display("FAIL frame_data: frame %0d pixel(%0d,%0d) got 0x%02h, required 0x%02h",
                     nframe, bad / 20, bad % 20, got[bad], e[bad]);
          end
          checks++;
          if (cyc - a != 64'd401) begin
            errors++;
            $display("FAIL latency: frame %0d got %0d cycles, required 401", nframe, cyc - a);
          end
        end
        nframe++;
      end
      ov_prev = out_valid && rst_n;
    end
  end

  initial begin : stim
    frame_t ramp, ff, snap, qf, f;
    int     n;
    logic   hold_bad;
    for (int i = 0; i < 400; i++) ramp[i] = 8'(i);
    for (int i = 0; i < 400; i++) ff[i] = 8'hFF;

    // Reset state
    repeat (3) @(negedge clk);
    qf = q;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || qf !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready %0b out_valid %0b q_zero %0b, required 0 0 1",
               in_ready, out_valid, qf == '0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: in_ready %0b, required 1", in_ready);
    end

    // Identity on ramp
    send(ramp, 36'h1);
    wait_idle();
    qf = q;
    checks++;
    if (qf !== ramp) begin
      errors++;
      $display("FAIL identity: q(0,1)=0x%02h q(19,19)=0x%02h, required 0x01 0x8f", qf[1], qf[399]);
    end

    // 90 deg: q(r,c) = src(c,19-r)
    send(ramp, 36'h1 << 9);
    wait_idle();
    check_pix("rot90_00", 0, 0, 8'd19);
    check_pix("rot90_1919", 19, 19, 8'h7C);

    // 180 deg: q(r,c) = src(19-r,19-c)
    send(ramp, 36'h1 << 18);
    wait_idle();
    check_pix("rot180_00", 0, 0, 8'h8F);
    check_pix("rot180_1919", 19, 19, 8'h00);

    // Zero vector and multi-bit vector
    send(rand_frame(), 36'h0);
    send(rand_frame(), 36'hF_0000_0600);

    // 40 deg on all-0xFF: corners out of bounds, centre filled
    send(ff, 36'h1 << 4);
    wait_idle();
    check_pix("rot40_c00", 0, 0, 8'h00);
    check_pix("rot40_c019", 0, 19, 8'h00);
    check_pix("rot40_c190", 19, 0, 8'h00);
    check_pix("rot40_c1919", 19, 19, 8'h00);
    for (int r = 8; r < 12; r++)
      for (int c = 8; c < 12; c++)
        check_pix("rot40_centre", r, c, 8'hFF);

    // Back-pressure in DONE
    nxt_in_rdy = 1'b0;
    send(rand_frame(), 36'h1 << 3);
    n = 0;
    while (!out_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    snap        = q;
    rdn_out_rdy = 1'b1;
    d           = rand_frame();
    angle_in    = 36'h1;
    hold_bad    = !out_valid;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      qf = q;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || qf !== snap) hold_bad = 1'b1;
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL done_hold: out_valid %0b in_ready %0b q_stable %0b, required 1 0 1",
               out_valid, in_ready, qf == snap);
    end
    rdn_out_rdy = 1'b0;
    nxt_in_rdy  = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_release: out_valid %0b in_ready %0b, required 0 1", out_valid, in_ready);
    end

    // Reset in the middle of a frame
    send(rand_frame(), 36'h1 << 5);
    repeat (200) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    qf = q;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || qf !== '0) begin
      errors++;
      $display("FAIL midframe_reset: in_ready %0b out_valid %0b q_zero %0b, required 0 0 1",
               in_ready, out_valid, qf == '0);
    end
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    f = rand_frame();
    send(f, 36'h1);
    wait_idle();
    qf = q;
    checks++;
    if (qf !== f) begin
      errors++;
      $display("FAIL post_reset_identity: q(0,0)=0x%02h, required 0x%02h", qf[0], f[0]);
    end

    // Random frames and angles
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) send(rand_frame(), {4'($urandom), 32'($urandom)});
      else            send(rand_frame(), 36'h1 << $urandom_range(0, 35));
    end

    // Drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
